t04_screen_bus_rx: RTL and testbench

Display-side receiver for the 8-bit 8080-style write bus (csx, dcx, wrx, data) driven by the team's screen interface. It decodes command/parameter bytes (CASET, PASET, RAMWR), tracks the column/page window and a write cursor, and emits one decoded pixel write per 16-bit RGB565 pair. It is used as the bench-side display model and as an on-chip loopback checker.

---
 rtl/t04_screen_rx_pkg.sv | 36 +++
 rtl/t04_bus_sync.sv | 48 ++++
 rtl/t04_screen_bus_rx.sv | 214 +++++++++++++++++++++
 tb/tb_t04_screen_bus_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t04_screen_rx_pkg.sv
// Shared command codes, decode states and coordinate helpers for the
// 8080-style screen bus receiver.
package t04_screen_rx_pkg;

  localparam int COORD_W = 9;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_OTHER
  } decode_state_t;

  function automatic decode_state_t cmd_to_state(input logic [7:0] code);
    case (code)
      CMD_NOP:   return ST_IDLE;
      CMD_CASET: return ST_CASET;
      CMD_PASET: return ST_PASET;
      CMD_RAMWR: return ST_RAMWR;
      default:   return ST_OTHER;
    endcase
  endfunction

  // Saturate a 16-bit bus coordinate onto the panel range.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [15:0] value,
                                                     input logic [15:0] max_value);
    return (value > max_value) ? max_value[COORD_W-1:0] : value[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/t04_bus_sync.sv
// Brings the asynchronous write bus into the clk domain and flags
// accepted bytes (wrx rise while selected) and chip-select release.
module t04_bus_sync
  #(parameter int SYNC_STAGES = 2)
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       csx,
    input  logic       dcx,
    input  logic       wrx,
    input  logic [7:0] data,
    output logic       byte_stb,
    output logic       byte_dcx,
    output logic [7:0] byte_data,
    output logic       cs_abort
  );

  // Idle bus: deselected with the strobe parked high, so reset never fakes an edge.
  localparam logic [10:0] IDLE_BUS = {1'b1, 1'b0, 1'b1, 8'h00};

  logic [10:0] sync_q [SYNC_STAGES];
  logic        wrx_prev;
  logic        csx_prev;
  logic        csx_s;
  logic        wrx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_BUS;
      wrx_prev <= 1'b1;
      csx_prev <= 1'b1;
    end else begin
      sync_q[0] <= {csx, dcx, wrx, data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wrx_prev <= wrx_s;
      csx_prev <= csx_s;
    end
  end

  assign csx_s     = sync_q[SYNC_STAGES-1][10];
  assign byte_dcx  = sync_q[SYNC_STAGES-1][9];
  assign wrx_s     = sync_q[SYNC_STAGES-1][8];
  assign byte_data = sync_q[SYNC_STAGES-1][7:0];

  assign byte_stb = wrx_s & ~wrx_prev & ~csx_s;
  assign cs_abort = csx_s & ~csx_prev;

endmodule

// File: rtl/t04_screen_bus_rx.sv
// Display-side decoder for CASET/PASET/RAMWR over the 8080 write bus.
// Optional running pixel checksum enabled by T04_SCREEN_RX_CHECKSUM_EN.
module t04_screen_bus_rx
  import t04_screen_rx_pkg::*;
  #(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
  )
  (
    input  logic               clk,
    input  logic               rst,
    input  logic               csx,
    input  logic               dcx,
    input  logic               wrx,
    input  logic [7:0]         data,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic [31:0]        pix_sum
  );

  localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

  logic       byte_stb;
  logic       byte_dcx;
  logic [7:0] byte_data;
  logic       cs_abort;

  t04_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .csx       (csx),
    .dcx       (dcx),
    .wrx       (wrx),
    .data      (data),
    .byte_stb  (byte_stb),
    .byte_dcx  (byte_dcx),
    .byte_data (byte_data),
    .cs_abort  (cs_abort)
  );

  decode_state_t      state_q, state_d;
  logic [2:0]         param_idx_q, param_idx_d;
  logic               byte_phase_q, byte_phase_d;
  logic [7:0]         hi_byte_q, hi_byte_d;
  logic [15:0]        start_q, start_d;
  logic [7:0]         end_hi_q, end_hi_d;
  logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic               pix_valid_d, cmd_valid_d;
  logic [COORD_W-1:0] pix_x_d, pix_y_d;
  logic [15:0]        pix_color_d;
  logic [7:0]         cmd_code_d;
  logic [15:0]        coord_limit;
  logic [COORD_W-1:0] commit_start, commit_end;

  // Window value that the fourth CASET/PASET parameter would commit.
  always_comb begin
    coord_limit  = (state_q == ST_PASET) ? Y_MAX : X_MAX;
    commit_start = clamp_coord(start_q, coord_limit);
    commit_end   = clamp_coord({end_hi_q, byte_data}, coord_limit);
    if (commit_end < commit_start) commit_end = commit_start;
  end

  always_comb begin
    state_d      = state_q;
    param_idx_d  = param_idx_q;
    byte_phase_d = byte_phase_q;
    hi_byte_d    = hi_byte_q;
    start_d      = start_q;
    end_hi_d     = end_hi_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x;
    pix_y_d      = pix_y;
    pix_color_d  = pix_color;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code;

    if (byte_stb) begin
      if (!byte_dcx) begin
        cmd_valid_d  = 1'b1;
        cmd_code_d   = byte_data;
        state_d      = cmd_to_state(byte_data);
        param_idx_d  = '0;
        byte_phase_d = 1'b0;
        if (byte_data == CMD_RAMWR) begin
          cur_x_d = xs_q;
          cur_y_d = ys_q;
        end
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            if (param_idx_q != 3'd4) param_idx_d = param_idx_q + 3'd1;
            case (param_idx_q)
              3'd0: start_d[15:8] = byte_data;
              3'd1: start_d[7:0]  = byte_data;
              3'd2: end_hi_d      = byte_data;
              3'd3: begin
                if (state_q == ST_CASET) begin
                  xs_d = commit_start;
                  xe_d = commit_end;
                end else begin
                  ys_d = commit_start;
                  ye_d = commit_end;
                end
              end
              default: ;
            endcase
          end
          ST_RAMWR: begin
            if (!byte_phase_q) begin
              hi_byte_d    = byte_data;
              byte_phase_d = 1'b1;
            end else begin
              byte_phase_d = 1'b0;
              pix_valid_d  = 1'b1;
              pix_color_d  = {hi_byte_q, byte_data};
              pix_x_d      = cur_x_q;
              pix_y_d      = cur_y_q;
              if (cur_x_q == xe_q) begin
                cur_x_d = xs_q;
                cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 1'b1;
              end else begin
                cur_x_d = cur_x_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Deselect drops any half-finished transaction after the byte above lands.
    if (cs_abort) begin
      state_d      = ST_IDLE;
      param_idx_d  = '0;
      byte_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      param_idx_q  <= '0;
      byte_phase_q <= 1'b0;
      hi_byte_q    <= '0;
      start_q      <= '0;
      end_hi_q     <= '0;
      xs_q         <= '0;
      xe_q         <= X_MAX[COORD_W-1:0];
      ys_q         <= '0;
      ye_q         <= Y_MAX[COORD_W-1:0];
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_color    <= '0;
      cmd_valid    <= 1'b0;
      cmd_code     <= '0;
    end else begin
      state_q      <= state_d;
      param_idx_q  <= param_idx_d;
      byte_phase_q <= byte_phase_d;
      hi_byte_q    <= hi_byte_d;
      start_q      <= start_d;
      end_hi_q     <= end_hi_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      pix_valid    <= pix_valid_d;
      pix_x        <= pix_x_d;
      pix_y        <= pix_y_d;
      pix_color    <= pix_color_d;
      cmd_valid    <= cmd_valid_d;
      cmd_code     <= cmd_code_d;
    end
  end

`ifdef T04_SCREEN_RX_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // Checksum restarts with each RAMWR so one frame can be compared at a time.
  always_comb begin
    sum_d = sum_q;
    if (byte_stb && !byte_dcx && (byte_data == CMD_RAMWR)) sum_d = '0;
    else if (pix_valid_d) sum_d = sum_q + {16'h0000, pix_color_d};
  end

  always_ff @(posedge clk) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign pix_sum = sum_q;
`else
  assign pix_sum = '0;
`endif

endmodule

// File: tb/tb_t04_screen_bus_rx.sv
// Self-checking bench for t04_screen_bus_rx: directed vector table,
// latency/checksum sequences and randomized traffic against a window model.
module tb_t04_screen_bus_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csx = 1'b1;
  logic        dcx = 1'b0;
  logic        wrx = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_color;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [31:0] pix_sum;

  t04_screen_bus_rx #(.WIDTH(240), .HEIGHT(320), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .csx       (csx),
    .dcx       (dcx),
    .wrx       (wrx),
    .data      (data),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .pix_sum   (pix_sum)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Pulse monitor, cleared at the start of every stimulus step.
  int          pixSeen = 0;
  int          cmdSeen = 0;
  logic [8:0]  lastX;
  logic [8:0]  lastY;
  logic [15:0] lastColor;
  logic [7:0]  lastCode;

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      pixSeen++;
      lastX = pix_x;
      lastY = pix_y;
      lastColor = pix_color;
    end
    if (cmd_valid === 1'b1) begin
      cmdSeen++;
      lastCode = cmd_code;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // kind: 0 = command byte, 1 = data byte, 2 = chip-select pulse
  task automatic applyStimulus(input int kind, input logic [7:0] d);
    @(negedge clk);
    pixSeen = 0;
    cmdSeen = 0;
    if (kind == 2) begin
      csx = 1'b1;
      repeat (4) @(negedge clk);
      csx = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      dcx  = (kind == 1);
      data = d;
      wrx  = 1'b0;
      repeat (2) @(negedge clk);
      wrx = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    csx = 1'b1;
    wrx = 1'b1;
    dcx = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    csx = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          kind;
    logic [7:0]  d;
    int          expPix;
    int          expX;
    int          expY;
    logic [15:0] expColor;
    int          expCmd;
    logic [7:0]  expCode;
  } vec_t;

  vec_t vecs[$];

  function automatic void addCmd(input logic [7:0] c);
    vecs.push_back('{0, c, 0, 0, 0, 16'h0, 1, c});
  endfunction
  function automatic void addData(input logic [7:0] d);
    vecs.push_back('{1, d, 0, 0, 0, 16'h0, 0, 8'h0});
  endfunction
  function automatic void addPix(input logic [7:0] hi, input logic [7:0] lo, input int x, input int y);
    vecs.push_back('{1, hi, 0, 0, 0, 16'h0, 0, 8'h0});
    vecs.push_back('{1, lo, 1, x, y, {hi, lo}, 0, 8'h0});
  endfunction
  function automatic void addAbort();
    vecs.push_back('{2, 8'h00, 0, 0, 0, 16'h0, 0, 8'h0});
  endfunction

  // Reference model: the cursor is the k-th pixel of a raster walk over the window.
  int          mXs, mXe, mYs, mYe;
  int          mCmd, mPc, mK, mHalf, mHi;
  int          mP [4];
  logic [31:0] mSum;

  function automatic void modelInit();
    mXs = 0; mXe = 239; mYs = 0; mYe = 319;
    mCmd = 0; mPc = 0; mK = 0; mHalf = 0; mHi = 0;
    mSum = 32'h0;
  endfunction

  function automatic void modelByte(input bit dc, input int d, output int ep, output int ex,
                                    output int ey, output logic [15:0] ec, output int ecmd);
    int s, e, lim, w, h;
    ep = 0; ex = 0; ey = 0; ec = 16'h0; ecmd = 0;
    if (!dc) begin
      ecmd = 1;
      mCmd = d; mPc = 0; mHalf = 0;
      if (d == 8'h2C) begin
        mK = 0;
        mSum = 32'h0;
      end
    end else if (mCmd == 8'h2A || mCmd == 8'h2B) begin
      if (mPc < 4) begin
        mP[mPc] = d;
        mPc++;
        if (mPc == 4) begin
          lim = (mCmd == 8'h2A) ? 239 : 319;
          s = mP[0] * 256 + mP[1];
          e = mP[2] * 256 + mP[3];
          if (s > lim) s = lim;
          if (e > lim) e = lim;
          if (e < s) e = s;
          if (mCmd == 8'h2A) begin mXs = s; mXe = e; end
          else begin mYs = s; mYe = e; end
        end
      end
    end else if (mCmd == 8'h2C) begin
      if (mHalf == 0) begin
        mHi = d;
        mHalf = 1;
      end else begin
        mHalf = 0;
        w = mXe - mXs + 1;
        h = mYe - mYs + 1;
        ep = 1;
        ec = 16'(mHi * 256 + d);
        ex = mXs + (mK % w);
        ey = mYs + ((mK / w) % h);
        mK++;
        mSum = mSum + {16'h0, ec};
      end
    end
  endfunction

  function automatic logic [31:0] expSum(input logic [31:0] modelValue);
`ifdef T04_SCREEN_RX_CHECKSUM_EN
    return modelValue;
`else
    return 32'h0 & modelValue;
`endif
  endfunction

  task automatic doByte(input bit dc, input logic [7:0] d);
    int ep, ex, ey, ecmd;
    logic [15:0] ec;
    modelByte(dc, int'(d), ep, ex, ey, ec, ecmd);
    applyStimulus(dc ? 1 : 0, d);
    checkOutput("rnd_pix_cnt", 32'(pixSeen), 32'(ep));
    if (ep == 1) begin
      checkOutput("rnd_pix_x", 32'(lastX), 32'(ex));
      checkOutput("rnd_pix_y", 32'(lastY), 32'(ey));
      checkOutput("rnd_pix_color", 32'(lastColor), 32'(ec));
    end
    checkOutput("rnd_cmd_cnt", 32'(cmdSeen), 32'(ecmd));
    if (ecmd == 1) checkOutput("rnd_cmd_code", 32'(lastCode), 32'(d));
    checkOutput("rnd_pix_sum", pix_sum, expSum(mSum));
  endtask

  task automatic doAbort();
    mCmd = 0; mPc = 0; mHalf = 0;
    applyStimulus(2, 8'h00);
    checkOutput("rnd_abort_pix", 32'(pixSeen), 32'd0);
    checkOutput("rnd_abort_cmd", 32'(cmdSeen), 32'd0);
  endtask

  task automatic sendWindow(input logic [7:0] c, input int lim);
    int s, e, n;
    s = $urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom_range(0, lim + 5);
    e = $urandom_range(0, 4) == 0 ? $urandom_range(0, 65535) : ((s + $urandom_range(0, 3) - 1) & 16'hFFFF);
    n = $urandom_range(0, 5) == 0 ? $urandom_range(1, 6) : 4;
    doByte(1'b0, c);
    for (int i = 0; i < n; i++) begin
      case (i)
        0: doByte(1'b1, 8'(s >> 8));
        1: doByte(1'b1, 8'(s));
        2: doByte(1'b1, 8'(e >> 8));
        3: doByte(1'b1, 8'(e));
        default: doByte(1'b1, 8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  initial begin
    int lat;
    bit got;
    int op;

    // Reset values observed while rst is held low
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("reset_pix_x", 32'(pix_x), 32'd0);
    checkOutput("reset_pix_y", 32'(pix_y), 32'd0);
    checkOutput("reset_pix_color", 32'(pix_color), 32'd0);
    checkOutput("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("reset_cmd_code", 32'(cmd_code), 32'd0);
    checkOutput("reset_pix_sum", pix_sum, 32'd0);
    doReset();

    addCmd(8'h2C);
    addPix(8'hF8, 8'h00, 0, 0);
    addCmd(8'h2A); addData(8'h00); addData(8'h0A); addData(8'h00); addData(8'h0B);
    addCmd(8'h2B); addData(8'h00); addData(8'h05); addData(8'h00); addData(8'h06);
    addCmd(8'h2C);
    addPix(8'h11, 8'h11, 10, 5);
    addPix(8'h22, 8'h22, 11, 5);
    addPix(8'h33, 8'h33, 10, 6);
    addPix(8'h44, 8'h44, 11, 6);
    addPix(8'h55, 8'h55, 10, 5);
    addCmd(8'h2A); addData(8'h01); addData(8'h2C); addData(8'h00); addData(8'h00);
    addCmd(8'h2C);
    addPix(8'hAA, 8'hBB, 239, 5);
    addPix(8'hCC, 8'hDD, 239, 6);
    addCmd(8'h2C);
    addData(8'hAB);
    addAbort();
    addCmd(8'h2C);
    addPix(8'h12, 8'h34, 239, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].kind, vecs[i].d);
      checkOutput($sformatf("v%0d_pix_cnt", i), 32'(pixSeen), 32'(vecs[i].expPix));
      if (vecs[i].expPix == 1) begin
        checkOutput($sformatf("v%0d_pix_x", i), 32'(lastX), 32'(vecs[i].expX));
        checkOutput($sformatf("v%0d_pix_y", i), 32'(lastY), 32'(vecs[i].expY));
        checkOutput($sformatf("v%0d_pix_color", i), 32'(lastColor), 32'(vecs[i].expColor));
      end
      checkOutput($sformatf("v%0d_cmd_cnt", i), 32'(cmdSeen), 32'(vecs[i].expCmd));
      if (vecs[i].expCmd == 1)
        checkOutput($sformatf("v%0d_cmd_code", i), 32'(lastCode), 32'(vecs[i].expCode));
    end

    // Latency from the first edge sampling raw wrx=1 to pix_valid
    applyStimulus(0, 8'h2C);
    applyStimulus(1, 8'h00);
    @(negedge clk);
    dcx = 1'b1;
    data = 8'h07;
    wrx = 1'b0;
    repeat (2) @(negedge clk);
    wrx = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (pix_valid === 1'b1 && !got) begin
        got = 1'b1;
        lat = e;
      end
    end
    checkOutput("latency_edges", 32'(lat), 32'(SYNC + 1));
    checkOutput("latency_color", 32'(pix_color), 32'h0007);

    // Checksum over a fresh RAMWR, then cleared by the next RAMWR
    applyStimulus(0, 8'h2C);
    applyStimulus(1, 8'h00);
    applyStimulus(1, 8'h01);
    applyStimulus(1, 8'hFF);
    applyStimulus(1, 8'hFF);
    checkOutput("checksum_two_pixels", pix_sum, expSum(32'h0001_0000));
    applyStimulus(0, 8'h2C);
    checkOutput("checksum_cleared", pix_sum, 32'h0);

    // Randomized traffic against the window model
    doReset();
    modelInit();
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        sendWindow(8'h2A, 239);
      end else if (op <= 3) begin
        sendWindow(8'h2B, 319);
      end else if (op <= 7) begin
        doByte(1'b0, 8'h2C);
        for (int b = 0; b < $urandom_range(1, 9); b++) doByte(1'b1, 8'($urandom_range(0, 255)));
      end else if (op == 8) begin
        doByte(1'b0, ($urandom_range(0, 1) == 1) ? 8'h29 : 8'h11);
        doByte(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        doAbort();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
